ps2_keyboard: RTL

//  PS/2 keyboard front end; produces the 16-bit Hack keyboard word consumed by memory's kbd

---
 rtl/hack_kbd_pkg.sv | 27 ++
 rtl/ps2_keyboard_if.sv | 16 +
 rtl/ps2_to_hack.sv | 68 ++++++
 rtl/ps2_keyboard.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/hack_kbd_pkg.sv
// Shared types and constants for the PS/2-to-Hack keyboard front end.
package hack_kbd_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam logic [7:0] HK_NEWLINE   = 8'd128;
  localparam logic [7:0] HK_BACKSPACE = 8'd129;
  localparam logic [7:0] HK_LEFT      = 8'd130;
  localparam logic [7:0] HK_UP        = 8'd131;
  localparam logic [7:0] HK_RIGHT     = 8'd132;
  localparam logic [7:0] HK_DOWN      = 8'd133;
  localparam logic [7:0] HK_HOME      = 8'd134;
  localparam logic [7:0] HK_END       = 8'd135;
  localparam logic [7:0] HK_PGUP      = 8'd136;
  localparam logic [7:0] HK_PGDN      = 8'd137;
  localparam logic [7:0] HK_INSERT    = 8'd138;
  localparam logic [7:0] HK_DELETE    = 8'd139;
  localparam logic [7:0] HK_ESC       = 8'd140;
  localparam logic [7:0] HK_F1        = 8'd141;
  localparam logic [7:0] HK_F12       = 8'd152;

endpackage

// File: rtl/ps2_keyboard_if.sv
// Connector-side lines and Hack-side outputs of the keyboard front end.
interface ps2_keyboard_if;
  import hack_kbd_pkg::*;

  // scan_valid and frame_err are single-cycle pulses with no ready/backpressure:
  // at most one fires per received frame, and kbd is already updated when scan_valid is high.
  logic         ps2_clk;
  logic         ps2_data;
  logic [15:0]  kbd;
  logic         scan_valid;
  logic         frame_err;
  frame_state_e dbg_state;

  modport master (output ps2_clk, ps2_data, input kbd, scan_valid, frame_err, dbg_state);
  modport slave  (input ps2_clk, ps2_data, output kbd, scan_valid, frame_err, dbg_state);
endinterface

// File: rtl/ps2_to_hack.sv
// Combinational map from a (possibly E0-extended) set-2 scan code plus shift to a Hack key code.
module ps2_to_hack
  import hack_kbd_pkg::*;
(
  input  logic        ext,
  input  logic [7:0]  code,
  input  logic        shift,
  output logic        valid,
  output logic [15:0] hack
);

  // {unshifted, shifted}; all-zero means the key has no Hack code
  logic [15:0] pair;

  always_comb begin
    pair = 16'h0000;
    if (ext) begin
      case (code)
        8'h6B:   pair = {2{HK_LEFT}};
        8'h75:   pair = {2{HK_UP}};
        8'h74:   pair = {2{HK_RIGHT}};
        8'h72:   pair = {2{HK_DOWN}};
        8'h6C:   pair = {2{HK_HOME}};
        8'h69:   pair = {2{HK_END}};
        8'h7D:   pair = {2{HK_PGUP}};
        8'h7A:   pair = {2{HK_PGDN}};
        8'h70:   pair = {2{HK_INSERT}};
        8'h71:   pair = {2{HK_DELETE}};
        default: pair = 16'h0000;
      endcase
    end else begin
      case (code)
        8'h1C: pair = "aA";  8'h32: pair = "bB";  8'h21: pair = "cC";  8'h23: pair = "dD";
        8'h24: pair = "eE";  8'h2B: pair = "fF";  8'h34: pair = "gG";  8'h33: pair = "hH";
        8'h43: pair = "iI";  8'h3B: pair = "jJ";  8'h42: pair = "kK";  8'h4B: pair = "lL";
        8'h3A: pair = "mM";  8'h31: pair = "nN";  8'h44: pair = "oO";  8'h4D: pair = "pP";
        8'h15: pair = "qQ";  8'h2D: pair = "rR";  8'h1B: pair = "sS";  8'h2C: pair = "tT";
        8'h3C: pair = "uU";  8'h2A: pair = "vV";  8'h1D: pair = "wW";  8'h22: pair = "xX";
        8'h35: pair = "yY";  8'h1A: pair = "zZ";
        8'h45: pair = "0)";  8'h16: pair = "1!";  8'h1E: pair = "2@";  8'h26: pair = "3#";
        8'h25: pair = "4$";  8'h2E: pair = "5%";  8'h36: pair = "6^";  8'h3D: pair = "7&";
        8'h3E: pair = "8*";  8'h46: pair = "9(";
        8'h0E: pair = "`~";  8'h4E: pair = "-_";  8'h55: pair = "=+";  8'h54: pair = "[{";
        8'h5B: pair = "]}";  8'h5D: pair = {8'h5C, 8'h7C}; 8'h4C: pair = ";:";  8'h52: pair = {8'h27, 8'h22};
        8'h41: pair = ",<";  8'h49: pair = ".>";  8'h4A: pair = "/?";  8'h29: pair = "  ";
        8'h5A: pair = {2{HK_NEWLINE}};
        8'h66: pair = {2{HK_BACKSPACE}};
        8'h76: pair = {2{HK_ESC}};
        8'h05: pair = {2{HK_F1}};
        8'h06: pair = {2{HK_F1 + 8'd1}};
        8'h04: pair = {2{HK_F1 + 8'd2}};
        8'h0C: pair = {2{HK_F1 + 8'd3}};
        8'h03: pair = {2{HK_F1 + 8'd4}};
        8'h0B: pair = {2{HK_F1 + 8'd5}};
        8'h83: pair = {2{HK_F1 + 8'd6}};
        8'h0A: pair = {2{HK_F1 + 8'd7}};
        8'h01: pair = {2{HK_F1 + 8'd8}};
        8'h09: pair = {2{HK_F1 + 8'd9}};
        8'h78: pair = {2{HK_F1 + 8'd10}};
        8'h07: pair = {2{HK_F12}};
        default: pair = 16'h0000;
      endcase
    end
    valid = (pair != 16'h0000);
    hack  = {8'h00, shift ? pair[7:0] : pair[15:8]};
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver and scan-code decoder producing the Hack keyboard word.
module ps2_keyboard
  import hack_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic          clk,
  input logic          rst_n,
  ps2_keyboard_if.slave bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
  logic filt_q, filt_d, strobe_q, strobe_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  frame_state_e state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic        scan_valid_q, scan_valid_d, frame_err_q, frame_err_d;
  logic        ext_q, ext_d, brk_q, brk_d, shift_q, shift_d;
  logic        held_vld_q, held_vld_d;
  logic [8:0]  held_q, held_d;
  logic [15:0] kbd_q, kbd_d;
  logic        byte_ok, map_valid;
  logic [15:0] map_hack;

  ps2_to_hack u_map (
    .ext   (ext_q),
    .code  (shreg_q),
    .shift (shift_q),
    .valid (map_valid),
    .hack  (map_hack)
  );

  always_comb begin
    clk_meta_d = bus.ps2_clk;
    clk_sync_d = clk_meta_q;
    dat_meta_d = bus.ps2_data;
    dat_sync_d = dat_meta_q;

    // the filtered clock only follows after FILTER_LEN identical samples of the new level
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FILT_LAST) filt_d = clk_sync_q;
      else filt_cnt_d = filt_cnt_q + 1'b1;
    end
    strobe_d = filt_q & ~filt_d;

    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    to_cnt_d     = '0;
    frame_err_d  = 1'b0;
    byte_ok      = 1'b0;
    if (strobe_q) begin
      case (state_q)
        IDLE: if (!dat_sync_q) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          shreg_d   = {dat_sync_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_sync_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if ((^{shreg_q, par_q}) && dat_sync_q) byte_ok = 1'b1;
          else frame_err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        state_d     = IDLE;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
    scan_valid_d = byte_ok;

    ext_d      = ext_q;
    brk_d      = brk_q;
    shift_d    = shift_q;
    held_d     = held_q;
    held_vld_d = held_vld_q;
    kbd_d      = kbd_q;
    if (byte_ok) begin
      if (shreg_q == SC_E0) begin
        ext_d = 1'b1;
      end else if (shreg_q == SC_F0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!ext_q && (shreg_q == SC_LSHIFT || shreg_q == SC_RSHIFT)) begin
          shift_d = ~brk_q;
        end else if (brk_q) begin
          // releasing some other key must not clear the one still held
          if (held_vld_q && held_q == {ext_q, shreg_q}) begin
            kbd_d      = 16'h0000;
            held_vld_d = 1'b0;
          end
        end else if (map_valid) begin
          kbd_d      = map_hack;
          held_d     = {ext_q, shreg_q};
          held_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q   <= 1'b1;
      clk_sync_q   <= 1'b1;
      dat_meta_q   <= 1'b1;
      dat_sync_q   <= 1'b1;
      filt_q       <= 1'b1;
      filt_cnt_q   <= '0;
      strobe_q     <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'h00;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      shift_q      <= 1'b0;
      held_q       <= 9'h000;
      held_vld_q   <= 1'b0;
      kbd_q        <= 16'h0000;
    end else begin
      clk_meta_q   <= clk_meta_d;
      clk_sync_q   <= clk_sync_d;
      dat_meta_q   <= dat_meta_d;
      dat_sync_q   <= dat_sync_d;
      filt_q       <= filt_d;
      filt_cnt_q   <= filt_cnt_d;
      strobe_q     <= strobe_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      shift_q      <= shift_d;
      held_q       <= held_d;
      held_vld_q   <= held_vld_d;
      kbd_q        <= kbd_d;
    end
  end

  assign bus.kbd        = kbd_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.dbg_state  = state_q;

endmodule
